// File: rtl/rr_arb_pkg.sv
// Shared constants, FSM encoding and one-hot encoder for the round-robin arbiter.
// Pure declarations; no clocked logic and no flow control.
package rr_arb_pkg;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // 4:2 encoder; an all-zero input encodes to 0.
  function automatic logic [IDW-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
    logic [IDW-1:0] idx;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (oh[k]) idx = IDW'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin pick: the first set request at or above i_ptr, wrapping 3->0.
// Zero latency; no flow control, the caller decides when the pick is taken.
module arb_rr_pick
  import rr_arb_pkg::*;
(
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_oh,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  logic [IDW-1:0] w_cand;
  logic           w_found;

  // The IDW-bit candidate index wraps modulo NREQ on its own.
  always_comb begin
    o_oh    = '0;
    w_found = 1'b0;
    w_cand  = i_ptr;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = i_ptr + IDW'(k);
      if (!w_found && i_req[w_cand]) begin
        w_found      = 1'b1;
        o_oh[w_cand] = 1'b1;
      end
    end
  end

  assign o_idx = onehot_to_idx(o_oh);
  assign o_any = |i_req;

endmodule

// File: rtl/rr_arb4_grant.sv
// Four-way round-robin arbiter with locked grants: grant registered one cycle after req is sampled,
// held until the owner drops req or en falls. RR_ARB_TIMEOUT_EN adds a MAX_HOLD revocation timer.
module rr_arb4_grant
  import rr_arb_pkg::*;
`ifdef RR_ARB_TIMEOUT_EN
#(
  parameter int MAX_HOLD = 8
)
`endif
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_vld,
`ifdef RR_ARB_TIMEOUT_EN
  output logic            timeout_pulse,
`endif
  output logic            busy
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  w_ptr_nxt;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] w_gnt_nxt;
  logic [IDW-1:0]  r_gnt_id;
  logic [IDW-1:0]  w_gnt_id_nxt;
  logic            w_release;
  logic [NREQ-1:0] w_pick_oh;
  logic [IDW-1:0]  w_pick_idx;
  logic            w_any;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD) + 1;
  logic [HW-1:0] r_hold;
  logic          r_timeout;
  logic          w_timeout;
`endif

  arb_rr_pick u_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_oh  (w_pick_oh),
    .o_idx (w_pick_idx),
    .o_any (w_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_gnt_id <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_gnt    <= w_gnt_nxt;
      r_gnt_id <= w_gnt_id_nxt;
    end
  end

  // en=0 releases without moving ptr, so the same owner wins again once enabled.
  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_gnt_nxt    = r_gnt;
    w_gnt_id_nxt = r_gnt_id;
    w_release    = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
    w_timeout    = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (en && w_any) begin
          w_state_nxt  = GRANT;
          w_gnt_nxt    = w_pick_oh;
          w_gnt_id_nxt = w_pick_idx;
        end
      end
      GRANT: begin
        if (!en) begin
          w_release = 1'b1;
        end else if (!req[r_gnt_id]) begin
          w_release = 1'b1;
          w_ptr_nxt = r_gnt_id + IDW'(1);
        end
`ifdef RR_ARB_TIMEOUT_EN
        else if (r_hold == HW'(MAX_HOLD - 1)) begin
          w_release = 1'b1;
          w_timeout = 1'b1;
          w_ptr_nxt = r_gnt_id + IDW'(1);
        end
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_release) begin
      w_state_nxt  = IDLE;
      w_gnt_nxt    = '0;
      w_gnt_id_nxt = '0;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  // Counter sits at zero while idle, so it starts from zero on every new grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeout;
      if (r_state == IDLE) begin
        r_hold <= '0;
      end else begin
        r_hold <= r_hold + HW'(1);
      end
    end
  end

  assign timeout_pulse = r_timeout;
`endif

  assign gnt     = r_gnt;
  assign gnt_id  = r_gnt_id;
  assign gnt_vld = |r_gnt;
  assign busy    = (r_state == GRANT);

endmodule

// File: tb/tb_rr_arb4_grant.sv
// Directed bench for rr_arb4_grant with a behavioural owner/pointer model checked every cycle.
module tb_rr_arb4_grant;
  import rr_arb_pkg::*;

  localparam int MAXH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_vld;
  logic       busy;
`ifdef RR_ARB_TIMEOUT_EN
  logic       timeout_pulse;
`endif

  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {
    logic       vld;
    logic [1:0] own;
    logic [1:0] ptr;
    logic [7:0] held;
    logic       to;
  } mst_t;

  mst_t m = '0;

  rr_arb4_grant dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .req           (req),
    .gnt           (gnt),
    .gnt_id        (gnt_id),
    .gnt_vld       (gnt_vld),
`ifdef RR_ARB_TIMEOUT_EN
    .timeout_pulse (timeout_pulse),
`endif
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: who owns the resource, where the search starts, how long the owner has held.
  function automatic mst_t model_next(input mst_t s, input logic e, input logic [3:0] r);
    mst_t n;
    int   c;
    bit   found;
    n     = s;
    n.to  = 1'b0;
    found = 1'b0;
    if (!s.vld) begin
      if (e) begin
        for (int k = 0; k < 4; k++) begin
          c = (int'(s.ptr) + k) % 4;
          if (!found && r[c]) begin
            found  = 1'b1;
            n.vld  = 1'b1;
            n.own  = 2'(c);
            n.held = 8'd0;
          end
        end
      end
    end else if (!e) begin
      n.vld = 1'b0;
    end else if (!r[s.own]) begin
      n.vld = 1'b0;
      n.ptr = 2'((int'(s.own) + 1) % 4);
    end
`ifdef RR_ARB_TIMEOUT_EN
    else if (int'(s.held) + 1 >= MAXH) begin
      n.vld = 1'b0;
      n.ptr = 2'((int'(s.own) + 1) % 4);
      n.to  = 1'b1;
    end
`endif
    else begin
      n.held = s.held + 8'd1;
    end
    return n;
  endfunction

  function automatic logic [3:0] m_gnt(input mst_t s);
    return s.vld ? (4'b0001 << s.own) : 4'b0000;
  endfunction

  function automatic logic [1:0] m_id(input mst_t s);
    return s.vld ? s.own : 2'd0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else     m <= model_next(m, en, req);
  end

  always @(negedge clk) begin
    chk("cmp_gnt",   {4'b0, gnt},    {4'b0, m_gnt(m)});
    chk("cmp_id",    {6'b0, gnt_id}, {6'b0, m_id(m)});
    chk("cmp_vld",   {7'b0, gnt_vld}, {7'b0, m.vld});
    chk("cmp_busy",  {7'b0, busy},    {7'b0, m.vld});
    chk("inv_onehot", {7'b0, $onehot0(gnt)}, 8'd1);
    chk("inv_known", {7'b0, $isunknown({gnt, gnt_id, gnt_vld, busy})}, 8'd0);
`ifdef RR_ARB_TIMEOUT_EN
    chk("cmp_to",    {7'b0, timeout_pulse}, {7'b0, m.to});
`endif
  end

  task automatic drive(input logic e, input logic [3:0] r);
    en  = e;
    req = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt",  {4'b0, gnt},     8'h00);
    chk("rst_id",   {6'b0, gnt_id},  8'h00);
    chk("rst_vld",  {7'b0, gnt_vld}, 8'h00);
    chk("rst_busy", {7'b0, busy},    8'h00);
    rst = 1'b0;
    drive(1'b0, 4'b0000);
    chk("idle_vld", {7'b0, gnt_vld}, 8'h00);

    // Single request, one-cycle latency, release moves ptr to 3.
    drive(1'b1, 4'b0100);
    chk("t1_gnt",  {4'b0, gnt},     8'h04);
    chk("t1_id",   {6'b0, gnt_id},  8'h02);
    chk("t1_vld",  {7'b0, gnt_vld}, 8'h01);
    drive(1'b1, 4'b0100);
    chk("t1_hold", {4'b0, gnt},     8'h04);
    drive(1'b1, 4'b0000);
    chk("t1_rel",  {4'b0, gnt},     8'h00);
    drive(1'b1, 4'b1111);
    chk("t1_ptr3", {6'b0, gnt_id},  8'h03);
    drive(1'b1, 4'b0111);
    chk("t1_rel2", {7'b0, gnt_vld}, 8'h00);

    // All requesting: rotation 0,1,2,3,0 with a dead cycle between grants.
    for (int i = 0; i < 5; i++) begin
      e = i % 4;
      drive(1'b1, 4'b1111);
      chk("t2_id",   {6'b0, gnt_id},  8'(e));
      drive(1'b1, 4'b1111);
      chk("t2_gnt",  {4'b0, gnt},     8'(1 << e));
      drive(1'b1, 4'b1111 & ~(4'b0001 << e));
      chk("t2_dead", {7'b0, gnt_vld}, 8'h00);
    end

    // Wrap from ptr=2.
    drive(1'b1, 4'b0010);
    chk("t3_id1",  {6'b0, gnt_id},  8'h01);
    drive(1'b1, 4'b0000);
    drive(1'b1, 4'b1011);
    chk("t3_wrap", {6'b0, gnt_id},  8'h03);
    drive(1'b1, 4'b0011);
    chk("t3_rel",  {7'b0, gnt_vld}, 8'h00);
    drive(1'b1, 4'b0011);
    chk("t3_id0",  {6'b0, gnt_id},  8'h00);
    drive(1'b1, 4'b0000);

    // Asynchronous reset mid-grant; ptr was 1, reset returns it to 0.
    drive(1'b1, 4'b0010);
    chk("t4_id1",  {6'b0, gnt_id},  8'h01);
    #2;
    rst = 1'b1;
    #1;
    chk("t4_async_gnt",  {4'b0, gnt},     8'h00);
    chk("t4_async_vld",  {7'b0, gnt_vld}, 8'h00);
    chk("t4_async_busy", {7'b0, busy},    8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 4'b0011);
    chk("t4_ptr0", {6'b0, gnt_id},  8'h00);
    drive(1'b1, 4'b0000);

    // en drop releases without advancing ptr (ptr=1 here).
    drive(1'b1, 4'b0110);
    chk("t5_id1",     {6'b0, gnt_id},  8'h01);
    drive(1'b0, 4'b0110);
    chk("t5_en_off",  {4'b0, gnt},     8'h00);
    drive(1'b1, 4'b0110);
    chk("t5_regrant", {6'b0, gnt_id},  8'h01);
    drive(1'b1, 4'b0000);
    drive(1'b0, 4'b1111);
    chk("t5_en_low",  {7'b0, gnt_vld}, 8'h00);

`ifdef RR_ARB_TIMEOUT_EN
    // Owner 0 holds req forever; revoked after MAXH cycles, then 1 wins.
    drive(1'b1, 4'b0001);
    chk("t6_id0", {6'b0, gnt_id}, 8'h00);
    for (int i = 0; i < MAXH - 1; i++) begin
      drive(1'b1, 4'b0011);
      chk("t6_held", {7'b0, gnt_vld}, 8'h01);
    end
    drive(1'b1, 4'b0011);
    chk("t6_revoke", {7'b0, gnt_vld},       8'h00);
    chk("t6_pulse",  {7'b0, timeout_pulse}, 8'h01);
    drive(1'b1, 4'b0011);
    chk("t6_next",   {6'b0, gnt_id},        8'h01);
    chk("t6_pulse0", {7'b0, timeout_pulse}, 8'h00);
    drive(1'b1, 4'b0000);
`endif

    drive(1'b0, 4'b0000);
    drive(1'b0, 4'b0000);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
